// File: rtl/fifo_wm_if.sv
// rtl/fifo_wm_if.sv - handshake, control and status bundle for the watermark FIFO
interface fifo_wm_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              flush;
    logic              clr_err;
    logic              push;
    logic [DATA_W-1:0] datain;
    logic              pull;
    logic [DATA_W-1:0] dataout;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    modport master (
        output flush, clr_err, push, datain, pull,
        input  dataout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  flush, clr_err, push, datain, pull,
        output dataout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_wm.sv
// rtl/fifo_wm.sv - show-ahead synchronous FIFO with watermarks, flush and sticky error flags
module fifo_wm #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic      clk,
    input  logic      rst,
    fifo_wm_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);
    localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);
    localparam bit               AF_EN   = (AF_LEVEL != 0);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wp;
    logic [PTR_W-1:0]  r_rp;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic w_full;
    logic w_empty;
    logic w_push_ok;
    logic w_pull_ok;
    logic w_wr_en;

    // Explicit wrap so any DEPTH works, not just powers of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_P) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);

    // A pull frees a slot at full, but an empty FIFO never bypasses push data to the reader.
    assign w_pull_ok = bus.pull && !w_empty;
    assign w_push_ok = bus.push && (!w_full || bus.pull);
    assign w_wr_en   = w_push_ok && !rst && !bus.flush;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wp] <= bus.datain;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wp <= ptr_inc(r_wp);
            end
            if (w_pull_ok) begin
                r_rp <= ptr_inc(r_rp);
            end
            r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pull_ok);
        end
    end

    // A fresh error on the same edge as clr_err leaves its bit set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.clr_err) begin
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end
            if (!bus.flush && bus.push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            if (!bus.flush && bus.pull && !w_pull_ok) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.dataout      = r_mem[r_rp];
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = AF_EN && (r_count >= AF_C);
    assign bus.almost_empty = (r_count <= AE_C);
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule
